// File: rtl/ddr3_cache_pkg.sv
// ddr3_cache_pkg
//   Shared constants and request/response records for the DDR3 cache
//   controller address path. The defaults describe the production frame
//   ring: 1024 frames, 10 subframe slots per frame, 32 KiB per slot.
package ddr3_cache_pkg;

    localparam int DEF_FRAME_W        = 16;
    localparam int DEF_SUBF_W         = 4;
    localparam int DEF_RING_BITS      = 10;
    localparam int DEF_SUBF_PER_FRAME = 10;
    localparam int DEF_SLOT_SHIFT     = 15;
    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_ERRCNT_W       = 16;

    typedef struct packed {
        logic [DEF_FRAME_W-1:0] frame;
        logic [DEF_SUBF_W-1:0]  subframe;
    } addr_req;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic                  err;
        logic                  lap;
    } addr_rsp;

endpackage

// File: rtl/frame_addr_stage.sv
// frame_addr_stage
//   One valid/data register slice of the frame address pipeline.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     i_en           advance enable; when low the slice holds
//     i_vld, i_data  incoming valid and payload
//     o_vld, o_data  registered valid and payload
//   Payload only loads on a valid beat, so a bubble leaves the last
//   result visible on the data lines.
module frame_addr_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_vld,
    input  logic [W-1:0] i_data,
    output logic         o_vld,
    output logic [W-1:0] o_data
);

    logic         r_vld;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
        end else if (i_en) begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_data <= i_data;
            end
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;

endmodule

// File: rtl/frame_addr_gen.sv
// frame_addr_gen
//   Streaming (frame, subframe) -> DDR3 slot base address converter for
//   the frame ring buffer. Three register stages, one global advance
//   enable, full throughput.
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     cfg_startframe, cfg_base    ring origin frame and byte base address
//     in_valid/in_ready           request handshake
//     in_frame, in_subframe       request fields
//     out_valid/out_ready         result handshake
//     out_addr, out_err, out_lap  slot address, bad-subframe, ring-lap flags
//     err_count, err_clr          saturating bad-subframe counter and clear
module frame_addr_gen
    import ddr3_cache_pkg::*;
#(
    parameter int FRAME_W        = DEF_FRAME_W,
    parameter int SUBF_W         = DEF_SUBF_W,
    parameter int RING_BITS      = DEF_RING_BITS,
    parameter int SUBF_PER_FRAME = DEF_SUBF_PER_FRAME,
    parameter int SLOT_SHIFT     = DEF_SLOT_SHIFT,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int ERRCNT_W       = DEF_ERRCNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [FRAME_W-1:0]  cfg_startframe,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [FRAME_W-1:0]  in_frame,
    input  logic [SUBF_W-1:0]   in_subframe,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                out_err,
    output logic                out_lap,
    output logic [ERRCNT_W-1:0] err_count,
    input  logic                err_clr
);

    // Largest index is 2^RING_BITS * SUBF_PER_FRAME - 1, which always fits here.
    localparam int IDX_W = RING_BITS + $clog2(SUBF_PER_FRAME);
    localparam int P0_W  = RING_BITS + SUBF_W + 2 + ADDR_W;
    localparam int P1_W  = IDX_W + 2 + ADDR_W;
    localparam int P2_W  = ADDR_W + 2;

    logic w_en;
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // ---- stage 1: ring offset, lap and subframe checks ----
    logic [FRAME_W-1:0]   w_diff;
    logic [RING_BITS-1:0] w_delta;
    logic                 w_lap;
    logic                 w_err;
    logic [SUBF_W-1:0]    w_sf;
    logic [P0_W-1:0]      w_d_in;

    assign w_diff  = in_frame - cfg_startframe;
    assign w_delta = w_diff[RING_BITS-1:0];
    assign w_lap   = (w_diff >> RING_BITS) != '0;
    assign w_err   = 32'(in_subframe) >= 32'(SUBF_PER_FRAME);
    // A bad subframe still yields a usable address: slot 0 of its frame.
    assign w_sf    = w_err ? '0 : in_subframe;
    assign w_d_in  = {w_delta, w_sf, w_err, w_lap, cfg_base};

    logic            w_vld_p0;
    logic [P0_W-1:0] w_d_p0;

    frame_addr_stage #(.W(P0_W)) u_stage_p0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_en),
        .i_vld  (in_valid),
        .i_data (w_d_in),
        .o_vld  (w_vld_p0),
        .o_data (w_d_p0)
    );

    // ---- stage 2: slot index = delta * SUBF_PER_FRAME + sf ----
    logic [RING_BITS-1:0] w_delta_p0;
    logic [SUBF_W-1:0]    w_sf_p0;
    logic                 w_err_p0;
    logic                 w_lap_p0;
    logic [ADDR_W-1:0]    w_base_p0;
    logic [IDX_W-1:0]     w_index;
    logic [P1_W-1:0]      w_d_mid;

    assign {w_delta_p0, w_sf_p0, w_err_p0, w_lap_p0, w_base_p0} = w_d_p0;
    assign w_index = IDX_W'(w_delta_p0) * IDX_W'(SUBF_PER_FRAME) + IDX_W'(w_sf_p0);
    assign w_d_mid = {w_index, w_err_p0, w_lap_p0, w_base_p0};

    logic            w_vld_p1;
    logic [P1_W-1:0] w_d_p1;

    frame_addr_stage #(.W(P1_W)) u_stage_p1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_en),
        .i_vld  (w_vld_p0),
        .i_data (w_d_mid),
        .o_vld  (w_vld_p1),
        .o_data (w_d_p1)
    );

    // ---- stage 3: byte address, wraps silently at 2^ADDR_W ----
    logic [IDX_W-1:0]  w_index_p1;
    logic              w_err_p1;
    logic              w_lap_p1;
    logic [ADDR_W-1:0] w_base_p1;
    logic [ADDR_W-1:0] w_addr;
    logic [P2_W-1:0]   w_d_out;

    assign {w_index_p1, w_err_p1, w_lap_p1, w_base_p1} = w_d_p1;
    assign w_addr  = w_base_p1 + (ADDR_W'(w_index_p1) << SLOT_SHIFT);
    assign w_d_out = {w_addr, w_err_p1, w_lap_p1};

    logic            w_vld_p2;
    logic [P2_W-1:0] w_d_p2;

    frame_addr_stage #(.W(P2_W)) u_stage_p2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_en),
        .i_vld  (w_vld_p1),
        .i_data (w_d_out),
        .o_vld  (w_vld_p2),
        .o_data (w_d_p2)
    );

    assign out_valid = w_vld_p2;
    assign {out_addr, out_err, out_lap} = w_d_p2;

    // Counts accepted bad-subframe requests; clear wins over increment.
    logic [ERRCNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end else if (in_valid && w_en && w_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
        end
    end

    assign err_count = r_err_cnt;

endmodule

// File: tb/tb_frame_addr_gen.sv
// tb_frame_addr_gen
//   Directed bench for frame_addr_gen: default build plus a 4-bit error
//   counter build sharing the same stimulus. Inputs change on the falling
//   edge, outputs are read on the falling edge.
module tb_frame_addr_gen;
    import ddr3_cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cfg_startframe;
    logic [31:0] cfg_base;
    logic        in_valid;
    logic [15:0] in_frame;
    logic [3:0]  in_subframe;
    logic        out_ready;
    logic        err_clr;

    logic        in_ready,  in_ready4;
    logic        out_valid, out_valid4;
    logic [31:0] out_addr,  out_addr4;
    logic        out_err,   out_err4;
    logic        out_lap,   out_lap4;
    logic [15:0] err_count;
    logic [3:0]  err_count4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    frame_addr_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_startframe (cfg_startframe),
        .cfg_base       (cfg_base),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_frame       (in_frame),
        .in_subframe    (in_subframe),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_addr       (out_addr),
        .out_err        (out_err),
        .out_lap        (out_lap),
        .err_count      (err_count),
        .err_clr        (err_clr)
    );

    frame_addr_gen #(.ERRCNT_W(4)) dut4 (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_startframe (cfg_startframe),
        .cfg_base       (cfg_base),
        .in_valid       (in_valid),
        .in_ready       (in_ready4),
        .in_frame       (in_frame),
        .in_subframe    (in_subframe),
        .out_valid      (out_valid4),
        .out_ready      (out_ready),
        .out_addr       (out_addr4),
        .out_err        (out_err4),
        .out_lap        (out_lap4),
        .err_count      (err_count4),
        .err_clr        (err_clr)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Call at a falling edge with an empty pipe and out_ready=1.
    task automatic issue(input string tag, input logic [15:0] frame,
                         input logic [3:0] sf, input addr_rsp exp);
        in_frame    = frame;
        in_subframe = sf;
        in_valid    = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            if (k < 3) check_eq({tag, "_early"}, 64'(out_valid), 64'd0);
        end
        check_eq({tag, "_vld"},  64'(out_valid), 64'd1);
        check_eq({tag, "_addr"}, 64'(out_addr),  64'(exp.addr));
        check_eq({tag, "_err"},  64'(out_err),   64'(exp.err));
        check_eq({tag, "_lap"},  64'(out_lap),   64'(exp.lap));
        check_eq({tag, "_addr4"}, 64'({out_addr4, out_err4, out_lap4}),
                 64'({exp.addr, exp.err, exp.lap}));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, tx, rx, stall;
        logic        prev_stall;
        logic [31:0] prev_addr;

        rst_n = 1'b0; cfg_startframe = '0; cfg_base = '0;
        in_valid = 1'b0; in_frame = '0; in_subframe = '0;
        out_ready = 1'b1; err_clr = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_vld",   64'(out_valid), 64'd0);
        check_eq("rst_addr",  64'(out_addr),  64'd0);
        check_eq("rst_flags", 64'({out_err, out_lap}), 64'd0);
        check_eq("rst_cnt",   64'(err_count), 64'd0);
        check_eq("rst_vld4",  64'(out_valid4), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_rdy",  64'(in_ready),  64'd1);
        check_eq("rst_rdy4", 64'(in_ready4), 64'd1);

        // Basic mapping: delta 2, index 23
        cfg_base = 32'h0; cfg_startframe = 16'h0005;
        issue("map", 16'h0007, 4'd3, '{addr: 32'h000B8000, err: 1'b0, lap: 1'b0});

        // Negative offset: delta 1022, index 10220
        issue("wrap", 16'h0003, 4'd0, '{addr: 32'h13F60000, err: 1'b0, lap: 1'b1});

        // Base offset with bad subframe -> slot 0 of frame 1
        cfg_base = 32'h4000_0000; cfg_startframe = 16'h0000;
        issue("base_err", 16'h0001, 4'd12, '{addr: 32'h40050000, err: 1'b1, lap: 1'b0});
        check_eq("cnt_one",  64'(err_count),  64'd1);
        check_eq("cnt4_one", 64'(err_count4), 64'd1);

        // Clear together with another bad request: clear wins
        in_frame = 16'h0002; in_subframe = 4'd15; in_valid = 1'b1; err_clr = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; err_clr = 1'b0;
        check_eq("cnt_clr", 64'(err_count), 64'd0);
        repeat (2) @(negedge clk);
        check_eq("clr_req_vld",  64'(out_valid), 64'd1);
        check_eq("clr_req_addr", 64'(out_addr),  64'h400A0000);
        check_eq("clr_req_err",  64'(out_err),   64'd1);
        @(negedge clk);

        // Subframe, lap and address-wrap boundaries
        cfg_base = 32'h0; cfg_startframe = 16'h0000;
        issue("sf9",  16'h0000, 4'd9,  '{addr: 32'h00048000, err: 1'b0, lap: 1'b0});
        issue("sf10", 16'h0000, 4'd10, '{addr: 32'h00000000, err: 1'b1, lap: 1'b0});
        cfg_startframe = 16'h1000;
        issue("lap_last",  16'h13FF, 4'd0, '{addr: 32'h13FB0000, err: 1'b0, lap: 1'b0});
        issue("lap_first", 16'h1400, 4'd1, '{addr: 32'h00008000, err: 1'b0, lap: 1'b1});
        cfg_base = 32'hFFFF_0000; cfg_startframe = 16'h0000;
        issue("addr_wrap", 16'h0000, 4'd2, '{addr: 32'h00000000, err: 1'b0, lap: 1'b0});

        // Backpressure: frames 0..7, out_ready low for cycles 2..8
        cfg_base = 32'h0;
        t = 0; tx = 0; rx = 0; stall = 0; prev_stall = 1'b0; prev_addr = '0;
        while (rx < 8 && t < 60) begin
            out_ready   = !(t >= 2 && t <= 8);
            in_valid    = (tx < 8);
            in_frame    = 16'(tx);
            in_subframe = 4'd0;
            #1;
            if (prev_stall) begin
                check_eq("bp_hold_vld",  64'(out_valid), 64'd1);
                check_eq("bp_hold_addr", 64'(out_addr),  64'(prev_addr));
            end
            if (!in_ready) stall++;
            if (in_valid && in_ready) tx++;
            if (out_valid && out_ready) begin
                check_eq("bp_order", 64'(out_addr), 64'(rx) * 64'h50000);
                rx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_addr  = out_addr;
            @(negedge clk);
            t++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check_eq("bp_rx",    64'(rx),    64'd8);
        check_eq("bp_tx",    64'(tx),    64'd8);
        check_eq("bp_stall", 64'(stall), 64'd6);
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_nodup", 64'(out_valid), 64'd0);
            @(negedge clk);
        end

        // Saturation: 20 bad requests
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("sat_clr", 64'(err_count4), 64'd0);
        in_frame = 16'h0000; in_subframe = 4'd15; in_valid = 1'b1;
        repeat (20) @(negedge clk);
        in_valid = 1'b0;
        check_eq("sat_cnt16", 64'(err_count),  64'd20);
        check_eq("sat_cnt4",  64'(err_count4), 64'd15);
        repeat (4) @(negedge clk);

        // Reset with three requests in flight
        in_subframe = 4'd0; in_valid = 1'b1;
        for (int f = 0; f < 3; f++) begin
            in_frame = 16'(f);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_vld",  64'(out_valid), 64'd0);
        check_eq("mid_rst_addr", 64'(out_addr),  64'd0);
        check_eq("mid_rst_cnt",  64'(err_count), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("post_rst_idle", 64'(out_valid), 64'd0);
        end
        issue("post_rst", 16'h0004, 4'd1, '{addr: 32'h00148000, err: 1'b0, lap: 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
